// File: rtl/fp_normalize_if.sv
// Valid/ready bundle between the mantissa adder (master) and the normalizer (slave).
// The master drives the operand side and out_ready; the slave drives the result side.
interface fp_normalize_if #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [MANT_W:0]   in_mantissa;
    logic [EXP_W-1:0]  in_exponent;

    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [EXP_W-1:0]  out_exponent;
    logic [MANT_W-2:0] out_fraction;
    logic              out_zero;
    logic              out_overflow;
    logic              out_underflow;

    modport master (
        output in_valid, in_sign, in_mantissa, in_exponent, out_ready,
        input  in_ready, out_valid, out_sign, out_exponent, out_fraction,
               out_zero, out_overflow, out_underflow
    );

    modport slave (
        input  in_valid, in_sign, in_mantissa, in_exponent, out_ready,
        output in_ready, out_valid, out_sign, out_exponent, out_fraction,
               out_zero, out_overflow, out_underflow
    );
endinterface

// File: rtl/fp_normalize.sv
// Post-add normalizer: renormalizes the raw mantissa sum one left shift per cycle and
// reports zero / overflow / underflow; one transaction in flight, valid/ready on both sides.
module fp_normalize #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    fp_normalize_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EVAL, SHIFT, OUT} state_e;

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

    state_e            state_q;
    logic              sign_q;
    logic [MANT_W:0]   mant_q;
    logic [EXP_W-1:0]  exp_q;

    logic              out_valid_q;
    logic              out_sign_q;
    logic [EXP_W-1:0]  out_exp_q;
    logic [MANT_W-2:0] out_frac_q;
    logic              out_zero_q;
    logic              out_ovf_q;
    logic              out_unf_q;

    // NOTE: every register here is state, so all updates are non-blocking (<=);
    // blocking assignments would let later branches see half-updated values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            mant_q      <= '0;
            exp_q       <= '0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_frac_q  <= '0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q  <= bus.in_sign;
                        mant_q  <= bus.in_mantissa;
                        exp_q   <= bus.in_exponent;
                        state_q <= EVAL;
                    end
                end

                EVAL: begin
                    out_sign_q <= sign_q;
                    out_zero_q <= 1'b0;
                    out_ovf_q  <= 1'b0;
                    out_unf_q  <= 1'b0;
                    if (mant_q == '0) begin
                        out_zero_q  <= 1'b1;
                        out_exp_q   <= '0;
                        out_frac_q  <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else if (mant_q[MANT_W]) begin
                        // Carry out: one right shift, the dropped LSB is simply truncated.
                        mant_q      <= mant_q >> 1;
                        out_exp_q   <= exp_q;
                        if (exp_q == EXP_ONES) begin
                            out_ovf_q  <= 1'b1;
                            out_frac_q <= '0;
                        end else begin
                            out_frac_q <= mant_q[MANT_W-1:1];
                        end
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else if (exp_q <= EXP_ONE) begin
                        out_unf_q   <= 1'b1;
                        exp_q       <= '0;
                        out_exp_q   <= '0;
                        out_frac_q  <= mant_q[MANT_W-2:0];
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else begin
                        // Undo the adder's pre-increment before normalizing left.
                        exp_q   <= exp_q - EXP_ONE;
                        state_q <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (mant_q[MANT_W-1]) begin
                        out_exp_q   <= exp_q;
                        out_frac_q  <= mant_q[MANT_W-2:0];
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else if (exp_q == EXP_ONE) begin
                        // Exponent floor reached: emit a denormal instead of wrapping.
                        out_unf_q   <= 1'b1;
                        exp_q       <= '0;
                        out_exp_q   <= '0;
                        out_frac_q  <= mant_q[MANT_W-2:0];
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else begin
                        mant_q <= mant_q << 1;
                        exp_q  <= exp_q - EXP_ONE;
                    end
                end

                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.out_valid     = out_valid_q;
    assign bus.out_sign      = out_sign_q;
    assign bus.out_exponent  = out_exp_q;
    assign bus.out_fraction  = out_frac_q;
    assign bus.out_zero      = out_zero_q;
    assign bus.out_overflow  = out_ovf_q;
    assign bus.out_underflow = out_unf_q;

endmodule

// File: tb/tb_fp_normalize.sv
// Scoreboard bench for fp_normalize: the driver queues hand-computed results, a negedge
// monitor checks every presented result (fields, first-valid latency, stability while stalled).
module tb_fp_normalize;
    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;

    fp_normalize_if #(.MANT_W(MANT_W), .EXP_W(EXP_W)) bus ();

    fp_normalize #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        logic       sign;
        logic [7:0] exp;
        logic [22:0] frac;
        logic       zero;
        logic       ovf;
        logic       unf;
        int         acc;
        int         lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the head of the scoreboard on every cycle a result is presented.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: out_valid=1 with empty scoreboard at cycle %0d", cyc);
                end else begin
                    mon_e = sb[0];
                    if (!prev_valid)
                        check({mon_e.name, ".latency"}, cyc - mon_e.acc, mon_e.lat);
                    check({mon_e.name, ".sign"},      bus.out_sign,      mon_e.sign);
                    check({mon_e.name, ".exponent"},  bus.out_exponent,  mon_e.exp);
                    check({mon_e.name, ".fraction"},  bus.out_fraction,  mon_e.frac);
                    check({mon_e.name, ".zero"},      bus.out_zero,      mon_e.zero);
                    check({mon_e.name, ".overflow"},  bus.out_overflow,  mon_e.ovf);
                    check({mon_e.name, ".underflow"}, bus.out_underflow, mon_e.unf);
                    if (bus.out_ready) void'(sb.pop_front());
                end
            end
            prev_valid = bus.out_valid;
        end
    end

    task automatic send(input string name, input logic s, input logic [24:0] m, input logic [7:0] e,
                        input logic [7:0] xe, input logic [22:0] xf,
                        input logic xz, input logic xo, input logic xu, input int lat);
        exp_t x;
        int   budget;
        budget = 0;
        while (!bus.in_ready) begin
            tick();
            budget++;
            if (budget > 200) begin
                checks++;
                failures++;
                $display("FAIL %s.accept: in_ready stayed 0 for %0d cycles", name, budget);
                return;
            end
        end
        bus.in_valid    = 1'b1;
        bus.in_sign     = s;
        bus.in_mantissa = m;
        bus.in_exponent = e;
        x.name = name; x.sign = s; x.exp = xe; x.frac = xf;
        x.zero = xz; x.ovf = xo; x.unf = xu; x.acc = cyc; x.lat = lat;
        sb.push_back(x);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 200) begin
            tick();
            budget++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s.drain: %0d results outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int budget;
        bus.in_valid    = 1'b0;
        bus.in_sign     = 1'b0;
        bus.in_mantissa = '0;
        bus.in_exponent = '0;
        bus.out_ready   = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset.out_valid",     bus.out_valid,     0);
        check("reset.in_ready",      bus.in_ready,      1);
        check("reset.out_sign",      bus.out_sign,      0);
        check("reset.out_exponent",  bus.out_exponent,  0);
        check("reset.out_fraction",  bus.out_fraction,  0);
        check("reset.out_zero",      bus.out_zero,      0);
        check("reset.out_overflow",  bus.out_overflow,  0);
        check("reset.out_underflow", bus.out_underflow, 0);
        rst_n = 1'b1;
        tick();

        //   name         sign mantissa      exp  -> exp   fraction   z  o  u  latency
        send("carry_1p5", 0, 25'h1800000, 128,  128, 23'h400000, 0, 0, 0, 2);
        send("norm_1p0",  1, 25'h0C00000, 128,  127, 23'h400000, 0, 0, 0, 3);
        send("shift_23",  0, 25'h0000001, 128,  104, 23'h000000, 0, 0, 0, 26);
        send("zero",      1, 25'h0000000, 90,   0,   23'h000000, 1, 0, 0, 2);
        send("overflow",  0, 25'h1000000, 255,  255, 23'h000000, 0, 1, 0, 2);
        send("shift_unf", 0, 25'h0000100, 3,    0,   23'h000200, 0, 0, 1, 4);
        send("carry_trn", 1, 25'h1FFFFFF, 200,  200, 23'h7FFFFF, 0, 0, 0, 2);
        send("eval_unf",  0, 25'h0C00000, 1,    0,   23'h400000, 0, 0, 1, 2);
        drain("directed");

        // Stall the result for five cycles and try to sneak in another operand meanwhile.
        bus.out_ready = 1'b0;
        send("stall", 0, 25'h0800000, 10, 9, 23'h000000, 0, 0, 0, 3);
        budget = 0;
        while (!bus.out_valid && budget < 50) begin
            tick();
            budget++;
        end
        check("stall.out_valid_seen", bus.out_valid, 1);
        bus.in_valid    = 1'b1;
        bus.in_mantissa = 25'h1234567;
        bus.in_exponent = 8'd77;
        repeat (5) begin
            check("stall.in_ready", bus.in_ready, 0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain("stall");

        // Abort mid-normalization with an asynchronous reset.
        send("abort", 0, 25'h0000001, 128, 104, 23'h000000, 0, 0, 0, 26);
        repeat (5) tick();
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort.out_valid",    bus.out_valid,    0);
        check("abort.in_ready",     bus.in_ready,     1);
        check("abort.out_exponent", bus.out_exponent, 0);
        tick();
        rst_n = 1'b1;
        tick();

        send("recover", 0, 25'h1800000, 128, 128, 23'h400000, 0, 0, 0, 2);
        drain("recover");
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
